// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: job sequencer for a weight-stationary systolic MAC array (kernel load, execute, drain)
module mac_array_ctrl #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int addr_bw = 11,
    parameter int len_bw  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [addr_bw-1:0] kernel_base,
    input  logic [addr_bw-1:0] act_base,
    input  logic [len_bw-1:0]  act_len,
    output logic               busy,
    output logic               done,
    output logic               rd_en,
    output logic [addr_bw-1:0] rd_addr,
    output logic [1:0]         inst_w,
    output logic               ofifo_wr
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] KLOAD = 3'd1;
    localparam logic [2:0] GAP   = 3'd2;
    localparam logic [2:0] EXEC  = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;
    localparam int lat = row + col - 1;
    localparam int cw  = $clog2(lat + (1 << len_bw) + col + 2);
    localparam logic [cw-1:0] lat_c  = cw'(lat);
    localparam logic [cw-1:0] klast  = cw'(col - 1);

    logic [2:0]         state;
    logic [cw-1:0]      cnt;
    logic [cw-1:0]      len_c;
    logic [addr_bw-1:0] kb;
    logic [addr_bw-1:0] ab;
    logic [len_bw-1:0]  len;
    logic [1:0]         rd_op;

    assign len_c = cw'(len);

    // Sequencer: cnt walks kernel reads, then counts from the first execute read until the last psum leaves
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            kb       <= '0;
            ab       <= '0;
            len      <= '0;
            rd_op    <= 2'b00;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            inst_w   <= 2'b00;
            ofifo_wr <= 1'b0;
        end else begin
            busy     <= state != IDLE;
            done     <= state == DONE;
            inst_w   <= rd_op;
            rd_en    <= 1'b0;
            rd_op    <= 2'b00;
            ofifo_wr <= (state == EXEC || state == DRAIN) && cnt > lat_c && cnt <= lat_c + len_c;
            case (state)
                IDLE: if (start) begin
                    kb    <= kernel_base;
                    ab    <= act_base;
                    len   <= act_len;
                    cnt   <= '0;
                    state <= KLOAD;
                end
                KLOAD: begin
                    rd_en   <= 1'b1;
                    rd_op   <= 2'b01;
                    rd_addr <= kb + addr_bw'(cnt);
                    cnt     <= cnt == klast ? '0 : cnt + 1'b1;
                    state   <= cnt == klast ? GAP : KLOAD;
                end
                GAP: state <= len == '0 ? DONE : EXEC;
                EXEC: begin
                    rd_en   <= 1'b1;
                    rd_op   <= 2'b10;
                    rd_addr <= ab + addr_bw'(cnt);
                    cnt     <= cnt + 1'b1;
                    state   <= cnt == len_c - 1'b1 ? DRAIN : EXEC;
                end
                DRAIN: begin
                    cnt   <= cnt + 1'b1;
                    state <= cnt == lat_c + len_c ? DONE : DRAIN;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_array_ctrl.sv
// tb_mac_array_ctrl: scoreboard bench; a job-level model predicts every read, opcode, strobe and done
module tb_mac_array_ctrl;
    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int AW  = 11;
    localparam int LW  = 8;
    localparam int LAT = ROW + COL - 1;
    localparam int AMASK = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] kernel_base = '0;
    logic [AW-1:0] act_base = '0;
    logic [LW-1:0] act_len = '0;
    logic          busy, done, rd_en, ofifo_wr;
    logic [AW-1:0] rd_addr;
    logic [1:0]    inst_w;

    mac_array_ctrl #(.row(ROW), .col(COL), .addr_bw(AW), .len_bw(LW)) dut (
        .clk(clk), .reset(reset), .start(start), .kernel_base(kernel_base),
        .act_base(act_base), .act_len(act_len), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .inst_w(inst_w), .ofifo_wr(ofifo_wr)
    );

    always #5 clk = ~clk;

    typedef struct {int c; int v;} ev_t;
    ev_t q_rd[$];
    ev_t q_in[$];
    ev_t q_wr[$];
    ev_t q_dn[$];
    int  edge_n = 0;
    int  free_at = 0;
    int  busy_from = 0;
    int  busy_to = -1;
    int  n_chk = 0;
    int  n_fail = 0;
    int  done_cnt = 0;
    bit  rst_seen = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", nm, edge_n, act, exp);
        end
    endtask

    task automatic accept(input int c, input int kb, input int ab, input int len);
        int d;
        for (int i = 0; i < COL; i++) begin
            q_rd.push_back('{c + 1 + i, (kb + i) & AMASK});
            q_in.push_back('{c + 2 + i, 1});
        end
        for (int j = 0; j < len; j++) begin
            q_rd.push_back('{c + COL + 2 + j, (ab + j) & AMASK});
            q_in.push_back('{c + COL + 3 + j, 2});
            q_wr.push_back('{c + COL + 3 + LAT + j, 0});
        end
        d = (len == 0) ? c + COL + 2 : c + COL + 3 + LAT + len;
        q_dn.push_back('{d, 0});
        busy_from = c + 1;
        busy_to   = d;
        free_at   = d + 1;
    endtask

    always @(posedge clk) begin
        edge_n++;
        rst_seen = !reset;
        if (!reset) begin
            q_rd.delete();
            q_in.delete();
            q_wr.delete();
            q_dn.delete();
            free_at = edge_n + 1;
            busy_to = -1;
        end else if (start && edge_n >= free_at) begin
            accept(edge_n, int'(kernel_base), int'(act_base), int'(act_len));
        end
    end

    always @(negedge clk) begin
        ev_t e;
        if (edge_n > 0) begin
            if (rst_seen)
                chk("reset_outputs", {busy, done, rd_en, rd_addr, inst_w, ofifo_wr}, 0);
            chk("busy", busy, edge_n >= busy_from && edge_n <= busy_to);
            if (rd_en) begin
                chk("rd_expected", q_rd.size() > 0, 1);
                if (q_rd.size() > 0) begin
                    e = q_rd.pop_front();
                    chk("rd_cycle", edge_n, e.c);
                    chk("rd_addr", rd_addr, e.v);
                end
            end
            if (inst_w != 2'b00) begin
                chk("inst_expected", q_in.size() > 0, 1);
                if (q_in.size() > 0) begin
                    e = q_in.pop_front();
                    chk("inst_cycle", edge_n, e.c);
                    chk("inst_op", inst_w, e.v);
                end
            end
            if (ofifo_wr) begin
                chk("wr_expected", q_wr.size() > 0, 1);
                if (q_wr.size() > 0) begin
                    e = q_wr.pop_front();
                    chk("wr_cycle", edge_n, e.c);
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_expected", q_dn.size() > 0, 1);
                if (q_dn.size() > 0) begin
                    e = q_dn.pop_front();
                    chk("done_cycle", edge_n, e.c);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_free();
        int t = 0;
        while (edge_n + 1 < free_at && t < 5000) begin
            tick();
            t++;
        end
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (done_cnt < target && t < 2000) begin
            tick();
            t++;
        end
        chk("done_timeout", done_cnt >= target, 1);
    endtask

    task automatic job(input int kb, input int ab, input int len);
        wait_free();
        kernel_base = AW'(kb);
        act_base    = AW'(ab);
        act_len     = LW'(len);
        start       = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int seen;
        int t;
        tick();
        tick();
        reset = 1'b1;
        tick();
        job(32'h010, 32'h100, 4);
        wait_done(1);
        job(32'h020, 32'h200, 0);
        wait_done(2);
        wait_free();
        kernel_base = AW'(32'h033);
        act_base    = AW'(32'h344);
        act_len     = LW'(3);
        start = 1'b1;
        seen = 0;
        t = 0;
        while (seen < 2 && t < 500) begin
            tick();
            if (done) seen++;
            t++;
        end
        start = 1'b0;
        chk("b2b_dones", seen, 2);
        tick();
        job(32'h010, 32'h100, 4);
        repeat (10) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        repeat (3) tick();
        seen = done_cnt;
        job(32'h010, 32'h100, 4);
        wait_done(seen + 1);
        seen = done_cnt;
        job(32'h7FC, 32'h7F0, 255);
        wait_done(seen + 1);
        seen = done_cnt;
        job(32'h123, 32'h456, 20);
        wait_done(seen + 1);
        for (int n = 0; n < 6; n++) begin
            job(int'($urandom_range(0, AMASK)), int'($urandom_range(0, AMASK)), int'($urandom_range(0, 30)));
            while (edge_n + 1 < free_at) begin
                start       = ($urandom_range(0, 2) == 0);
                kernel_base = AW'($urandom);
                act_base    = AW'($urandom);
                act_len     = LW'($urandom);
                tick();
            end
            start = 1'b0;
        end
        wait_free();
        repeat (4) tick();
        chk("rd_left", q_rd.size(), 0);
        chk("inst_left", q_in.size(), 0);
        chk("wr_left", q_wr.size(), 0);
        chk("done_left", q_dn.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
